pixel_stream_source: RTL and testbench

//  Frame-buffer reader that produces the raster pixel stream consumed by the edge/Hough pipeline.
//  On Start it reads a Width x Height 8-bit image from a synchronous RAM in raster order.
//  It emits Pixel/Frame/Line markers with programmable horizontal and vertical blanking.
//  The blanking lets downstream line-buffer pipelines flush between lines and frames.

---
 rtl/pixel_stream_source.sv | 166 ++++++++++++++++
 tb/tb_pixel_stream_source.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_stream_source.sv
// Frame-buffer reader: walks a Width x Height image in raster order and emits
// pixels with Frame/Line markers, separated by fixed horizontal and vertical blanking.
module pixel_stream_source #(
    parameter int HBLANK = 4,
    parameter int VBLANK = 16,
    parameter int ADDR_W = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Continuous,
    input  logic [7:0]        Width,
    input  logic [7:0]        Height,
    output logic [ADDR_W-1:0] MemAddr,
    output logic              MemRe,
    input  logic [7:0]        MemData,
    output logic [7:0]        PixelOut,
    output logic              FrameOut,
    output logic              LineOut,
    output logic              Busy,
    output logic              Done
);
    localparam int BLANK_MAX = (HBLANK > VBLANK) ? HBLANK : VBLANK;
    localparam int CNT_W     = $clog2(BLANK_MAX + 1);
    localparam logic [CNT_W-1:0] HB_LAST = CNT_W'(HBLANK - 1);
    localparam logic [CNT_W-1:0] VB_LAST = CNT_W'(VBLANK - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_HBLANK = 2'd2,
        S_VBLANK = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        width_q, width_d;
    logic [7:0]        height_q, height_d;
    logic [7:0]        col_q, col_d;
    logic [7:0]        row_q, row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;

    logic dims_ok, last_col, frame_start;
    logic mem_re, first_line_px, first_frame_px;

    logic       vld_p0, line_p0, frame_p0;
    logic [7:0] pixel_p1;
    logic       line_p1, frame_p1;

    assign dims_ok     = (Width != 8'd0) && (Height != 8'd0);
    assign last_col    = (col_q == width_q - 8'd1);
    assign frame_start = (state_d == S_ACTIVE) &&
                         ((state_q == S_IDLE) || (state_q == S_VBLANK));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (Start && dims_ok) state_d = S_ACTIVE;
            S_ACTIVE: if (last_col) state_d = S_HBLANK;
            S_HBLANK: if (cnt_q == HB_LAST) state_d = (row_q < height_q) ? S_ACTIVE : S_VBLANK;
            S_VBLANK: if (cnt_q == VB_LAST) state_d = (Continuous && dims_ok) ? S_ACTIVE : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_re         = (state_q == S_ACTIVE);
        first_line_px  = mem_re && (col_q == 8'd0);
        first_frame_px = first_line_px && (row_q == 8'd0);
        done_d         = ((state_q == S_IDLE) && Start && !dims_ok) ||
                         ((state_q == S_VBLANK) && (state_d == S_IDLE));
    end

    // Raster walk: address advances by increment only, dims latched at frame start
    always_comb begin
        width_d  = width_q;
        height_d = height_q;
        col_d    = col_q;
        row_d    = row_q;
        addr_d   = addr_q;
        cnt_d    = '0;
        if (frame_start) begin
            width_d  = Width;
            height_d = Height;
            col_d    = 8'd0;
            row_d    = 8'd0;
            addr_d   = '0;
        end else if (state_q == S_ACTIVE) begin
            addr_d = addr_q + ADDR_W'(1);
            if (last_col) begin
                col_d = 8'd0;
                row_d = row_q + 8'd1;
            end else begin
                col_d = col_q + 8'd1;
            end
        end
        if (((state_q == S_HBLANK) || (state_q == S_VBLANK)) && (state_d == state_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            col_q  <= 8'd0;
            row_q  <= 8'd0;
            addr_q <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    always_ff @(posedge Clk) begin
        width_q  <= width_d;
        height_q <= height_d;
    end

    // Stage p0: read issued, RAM data arrives next cycle
    always_ff @(posedge Clk) begin
        if (Reset) begin
            vld_p0   <= 1'b0;
            line_p0  <= 1'b0;
            frame_p0 <= 1'b0;
        end else begin
            vld_p0   <= mem_re;
            line_p0  <= first_line_px;
            frame_p0 <= first_frame_px;
        end
    end

    // Stage p1: registered pixel, blanked when no read was in flight
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pixel_p1 <= 8'd0;
            line_p1  <= 1'b0;
            frame_p1 <= 1'b0;
        end else begin
            pixel_p1 <= vld_p0 ? MemData : 8'd0;
            line_p1  <= line_p0;
            frame_p1 <= frame_p0;
        end
    end

    assign MemRe    = mem_re;
    assign MemAddr  = mem_re ? addr_q : '0;
    assign PixelOut = pixel_p1;
    assign LineOut  = line_p1;
    assign FrameOut = frame_p1;
    assign Busy     = (state_q != S_IDLE);
    assign Done     = done_q;

endmodule

// File: tb/tb_pixel_stream_source.sv
// Bench for pixel_stream_source: per-cycle expected trace built from the raster,
// blanking and latency rules, compared against every DUT output each cycle.
module tb_pixel_stream_source;
    localparam int HB = 4;
    localparam int VB = 16;
    localparam int AW = 16;
    localparam int N  = 512;

    logic          Clk, Reset, Start, Continuous;
    logic [7:0]    Width, Height;
    logic [AW-1:0] MemAddr;
    logic          MemRe;
    logic [7:0]    MemData;
    logic [7:0]    PixelOut;
    logic          FrameOut, LineOut, Busy, Done;

    pixel_stream_source #(.HBLANK(HB), .VBLANK(VB), .ADDR_W(AW)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Continuous(Continuous),
        .Width(Width), .Height(Height), .MemAddr(MemAddr), .MemRe(MemRe),
        .MemData(MemData), .PixelOut(PixelOut), .FrameOut(FrameOut),
        .LineOut(LineOut), .Busy(Busy), .Done(Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic [7:0] mem [65536];

    // Synchronous RAM; junk on the bus when no read is issued
    always @(posedge Clk) begin
        if (MemRe) MemData <= mem[MemAddr];
        else       MemData <= 8'($urandom);
    end

    int n_cmp, n_fail;

    int e_re [N], e_addr [N], e_pix [N], e_frame [N], e_line [N], e_busy [N], e_done [N];
    int s_start [N], s_cont [N], s_rst [N], s_w [N], s_h [N];

    task automatic chk(input string what, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", what, cyc, obs, exp);
        end
    endtask

    task automatic clear_all();
        for (int k = 0; k < N; k++) begin
            e_re[k] = 0; e_addr[k] = 0; e_pix[k] = 0; e_frame[k] = 0;
            e_line[k] = 0; e_busy[k] = 0; e_done[k] = 0;
            s_start[k] = 0; s_cont[k] = 0; s_rst[k] = 0; s_w[k] = 0; s_h[k] = 0;
        end
    endtask

    task automatic new_image();
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    endtask

    task automatic set_dims(input int from, input int w, input int h);
        for (int k = from; k < N; k++) begin
            s_w[k] = w;
            s_h[k] = h;
        end
    endtask

    // Expected activity of one frame whose first read is in cycle s
    task automatic add_frame(input int s, input int w, input int h, input bit last, output int t_end);
        int t;
        t = s;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                e_re[t]      = 1;
                e_addr[t]    = r * w + c;
                e_pix[t+2]   = int'(mem[r * w + c]);
                e_line[t+2]  = (c == 0) ? 1 : 0;
                e_frame[t+2] = (c == 0 && r == 0) ? 1 : 0;
                t++;
            end
            t += HB;
        end
        t += VB;
        for (int k = s; k < t; k++) e_busy[k] = 1;
        if (last) e_done[t] = 1;
        t_end = t;
    endtask

    task automatic truncate(input int from);
        for (int k = from; k < N; k++) begin
            e_re[k] = 0; e_addr[k] = 0; e_pix[k] = 0; e_frame[k] = 0;
            e_line[k] = 0; e_busy[k] = 0; e_done[k] = 0;
        end
    endtask

    task automatic run(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge Clk);
            chk({tag, " MemRe"},    k, 32'(MemRe),    e_re[k]);
            chk({tag, " MemAddr"},  k, 32'(MemAddr),  e_re[k] != 0 ? e_addr[k] : 0);
            chk({tag, " PixelOut"}, k, 32'(PixelOut), e_pix[k]);
            chk({tag, " FrameOut"}, k, 32'(FrameOut), e_frame[k]);
            chk({tag, " LineOut"},  k, 32'(LineOut),  e_line[k]);
            chk({tag, " Busy"},     k, 32'(Busy),     e_busy[k]);
            chk({tag, " Done"},     k, 32'(Done),     e_done[k]);
            Start      = s_start[k][0];
            Continuous = s_cont[k][0];
            Width      = 8'(s_w[k]);
            Height     = 8'(s_h[k]);
            Reset      = s_rst[k][0];
        end
    endtask

    initial begin
        int t0, t1, w0, h0, w1, h1;
        n_cmp = 0;
        n_fail = 0;
        Reset = 1'b1; Start = 1'b0; Continuous = 1'b0; Width = 8'd0; Height = 8'd0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("reset MemRe",    0, 32'(MemRe),    0);
        chk("reset MemAddr",  0, 32'(MemAddr),  0);
        chk("reset PixelOut", 0, 32'(PixelOut), 0);
        chk("reset FrameOut", 0, 32'(FrameOut), 0);
        chk("reset LineOut",  0, 32'(LineOut),  0);
        chk("reset Busy",     0, 32'(Busy),     0);
        chk("reset Done",     0, 32'(Done),     0);
        Reset = 1'b0;

        // 3x2 directed image, single frame
        clear_all();
        new_image();
        for (int i = 0; i < 6; i++) mem[i] = 8'(10 * (i + 1));
        s_start[0] = 1;
        set_dims(0, 3, 2);
        add_frame(1, 3, 2, 1, t0);
        run("img3x2", t0 + 3);

        // zero width: Done only
        clear_all();
        s_start[0] = 1;
        set_dims(0, 0, 5);
        e_done[1] = 1;
        run("zerow", 6);

        // zero height: Done only
        clear_all();
        s_start[0] = 1;
        set_dims(0, 7, 0);
        e_done[1] = 1;
        run("zeroh", 6);

        // 1x1 image of 0xFF
        clear_all();
        new_image();
        mem[0] = 8'hFF;
        s_start[0] = 1;
        set_dims(0, 1, 1);
        add_frame(1, 1, 1, 1, t0);
        run("px1x1", t0 + 3);

        // continuous 4x3: three frames 40 cycles apart, then Done
        clear_all();
        new_image();
        s_start[0] = 1;
        set_dims(0, 4, 3);
        for (int k = 0; k < 100; k++) s_cont[k] = 1;
        add_frame(1, 4, 3, 0, t0);
        add_frame(t0, 4, 3, 0, t1);
        add_frame(t1, 4, 3, 1, t0);
        run("cont4x3", t0 + 3);

        // Start re-pulsed and dims changed while busy
        clear_all();
        new_image();
        s_start[0] = 1;
        s_start[4] = 1;
        s_start[12] = 1;
        set_dims(0, 5, 2);
        set_dims(1, 9, 7);
        add_frame(1, 5, 2, 1, t0);
        run("busyign", t0 + 3);

        // reset on 2nd pixel of line 1, then restart
        clear_all();
        new_image();
        set_dims(0, 3, 3);
        s_start[0] = 1;
        add_frame(1, 3, 3, 0, t0);
        s_rst[1 + (3 + HB) + 1] = 1;
        truncate(1 + (3 + HB) + 2);
        s_start[14] = 1;
        add_frame(15, 3, 3, 1, t0);
        run("midrst", t0 + 3);

        // randomized single frames
        for (int it = 0; it < 4; it++) begin
            clear_all();
            new_image();
            w0 = $urandom_range(10, 1);
            h0 = $urandom_range(6, 1);
            s_start[0] = 1;
            set_dims(0, w0, h0);
            set_dims(1, $urandom_range(255, 0), $urandom_range(255, 0));
            add_frame(1, w0, h0, 1, t0);
            run("rand", t0 + 3);
        end

        // randomized continuous pair with dims re-latched for the second frame
        clear_all();
        new_image();
        w0 = $urandom_range(10, 1);
        h0 = $urandom_range(6, 1);
        w1 = $urandom_range(10, 1);
        h1 = $urandom_range(6, 1);
        s_start[0] = 1;
        set_dims(0, w0, h0);
        set_dims(1, w1, h1);
        add_frame(1, w0, h0, 0, t0);
        for (int k = 0; k < t0; k++) s_cont[k] = 1;
        add_frame(t0, w1, h1, 1, t1);
        run("randcont", t1 + 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
